fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing the single write port of one fifo_cnt instance among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and the fifo_cnt write port.
// The arbiter takes the slave modport; producers and the FIFO side take the master modport.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          fifo_full;
  logic                          fifo_wen;
  logic [DATA_WIDTH-1:0]         fifo_din;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, grant, busy, fifo_wen, fifo_din
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, grant, busy, fifo_wen, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo_cnt write port among NUM_REQ valid/ready producers.
// Define FIFO_WR_ARB_STATS_EN to add the xfer_total write counter port.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_arbiter_if.slave    bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [31:0]         xfer_total
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]   last_ptr_reg, last_ptr_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [PTR_W-1:0]      sel;
  logic                  owner_valid;
  logic                  owner_ready;
  logic                  xfer;
  logic                  last_beat;

  // While granted, last_ptr_reg is the owner index and grant_reg its one-hot form.
  assign owner_valid = bus.req_valid[last_ptr_reg];
  assign owner_ready = (state_reg == GRANT) && !bus.fifo_full;
  assign xfer        = owner_ready && owner_valid;
  assign last_beat   = (beat_cnt_reg == CNT_W'(BURST_LEN - 1));

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]      = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign bus.req_ready[gi] = owner_ready && grant_reg[gi];
    end
  endgenerate

  assign bus.fifo_wen = xfer;
  assign bus.fifo_din = (state_reg == GRANT) ? data_arr[last_ptr_reg] : '0;
  assign bus.grant    = grant_reg;
  assign bus.busy     = (state_reg == GRANT);

  // Scan last_ptr+1 .. last_ptr+NUM_REQ; iterating downward lets the nearest valid win.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = '0;
    sel = last_ptr_reg;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PTR_W'((int'(last_ptr_reg) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        sel = idx;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_ptr_next = last_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.req_valid) begin
          state_next    = GRANT;
          grant_next    = NUM_REQ'(1) << sel;
          last_ptr_next = sel;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        // A dropped valid ends the burst even when the FIFO is full.
        if (!owner_valid) begin
          state_next = IDLE;
          grant_next = '0;
        end else if (xfer) begin
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          if (last_beat) begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      last_ptr_reg <= PTR_W'(NUM_REQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_ptr_reg <= last_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] xfer_total_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_total_reg <= '0;
    end else if (xfer) begin
      xfer_total_reg <= xfer_total_reg + 32'd1;
    end
  end

  assign xfer_total = xfer_total_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: producer queues, a FIFO occupancy model and a write scoreboard.
// Build with FIFO_WR_ARB_STATS_EN defined to also check the xfer_total port.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] xfer_total;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .xfer_total(xfer_total)
`endif
  );

  logic [DW-1:0] prod_q [NR][$];
  logic [DW-1:0] exp_q [$];
  int            exp_burst [$];
  int            exp_grant [$];
  logic [NR-1:0] en;
  logic          full_force;
  int            fifo_cnt;
  int            fifo_depth;
  int            total;
  int            bad;

  logic          s_wen, s_busy, s_full;
  logic [DW-1:0] s_din;
  logic [NR-1:0] s_ready, s_grant;

  function automatic logic [DW-1:0] tag(int i, int k);
    return DW'(i * 256 + k + 16);
  endfunction

  // Drive producer/FIFO inputs just after the falling edge, then sample outputs.
  task automatic drive_sample();
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    v;
    d = '0;
    v = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && prod_q[i].size() > 0) begin
        v[i] = 1'b1;
        d[i*DW +: DW] = prod_q[i][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.fifo_full = full_force || (fifo_cnt >= fifo_depth);
    #1;
    s_wen   = bus.fifo_wen;
    s_din   = bus.fifo_din;
    s_ready = bus.req_ready;
    s_grant = bus.grant;
    s_busy  = bus.busy;
    s_full  = bus.fifo_full;
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (s_ready[i] && bus.req_valid[i]) void'(prod_q[i].pop_front());
    end
    if (s_wen) fifo_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = '1;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 4; k++) prod_q[i].push_back(tag(i, k));
    for (int c = 0; c < 2; c++) begin
      drive_sample();
      total++;
      if (s_grant !== '0 || s_ready !== '0 || s_wen !== 1'b0 || s_busy !== 1'b0 || s_din !== '0) begin
        bad++;
        $display("FAIL reset_vals: grant=%b ready=%b wen=%b busy=%b din=%h want all zero",
                 s_grant, s_ready, s_wen, s_busy, s_din);
      end
`ifdef FIFO_WR_ARB_STATS_EN
      total++;
      if (xfer_total !== 32'd0) begin
        bad++;
        $display("FAIL reset_stats: xfer_total=%0d want 0", xfer_total);
      end
`endif
      advance();
    end
    rst = 1'b0;
    drive_sample();
    total++;
    if (s_busy !== 1'b0 || s_wen !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_latency: busy=%b wen=%b want 0 0", s_busy, s_wen);
    end
    advance();
    drive_sample();
    total++;
    if (s_grant !== 4'b0001 || s_ready !== 4'b0001 || s_wen !== 1'b1 || s_din !== tag(0, 0)) begin
      bad++;
      $display("FAIL reset_first_grant: grant=%b ready=%b wen=%b din=%h want 0001 0001 1 %h",
               s_grant, s_ready, s_wen, s_din, tag(0, 0));
    end
    advance();
    rst = 1'b1;
    drive_sample();
    total++;
    if (s_grant !== '0 || s_busy !== 1'b0 || s_wen !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_burst: grant=%b busy=%b wen=%b want 0000 0 0", s_grant, s_busy, s_wen);
    end
    advance();
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    en = '0;
  endtask

  task automatic test_single();
    logic prev_busy = 1'b0;
    int cyc = 0, cur = 0, idle = 0, bursts = 0, want;
    do_reset();
    en = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      prod_q[1].push_back(DW'(5 * (k + 1)));
      exp_q.push_back(DW'(5 * (k + 1)));
    end
    exp_burst = '{8, 8, 4};
    while ((prod_q[1].size() > 0 || prev_busy) && cyc < 100) begin
      drive_sample();
      if (s_wen) begin
        total++;
        if (exp_q.size() == 0 || s_din !== exp_q[0]) begin
          bad++;
          $display("FAIL single_data: din=%h want %h", s_din, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        cur++;
      end
      if (s_busy && !prev_busy) begin
        if (bursts > 0) begin
          total++;
          if (idle !== 1) begin
            bad++;
            $display("FAIL single_gap: idle cycles=%0d want 1", idle);
          end
        end
        total++;
        if (s_grant !== 4'b0010) begin
          bad++;
          $display("FAIL single_grant: grant=%b want 0010", s_grant);
        end
        bursts++;
        idle = 0;
      end
      if (!s_busy && prev_busy) begin
        want = (exp_burst.size() > 0) ? exp_burst.pop_front() : -1;
        total++;
        if (cur !== want) begin
          bad++;
          $display("FAIL single_burst_len: beats=%0d want %0d", cur, want);
        end
        cur = 0;
      end
      if (!s_busy) idle++;
      prev_busy = s_busy;
      advance();
      cyc++;
    end
    total++;
    if (cyc >= 100 || bursts !== 3 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL single_done: cycles=%0d bursts=%0d left=%0d want <100 3 0", cyc, bursts, exp_q.size());
    end
    en = '0;
  endtask

  task automatic test_fairness();
    logic prev_busy = 1'b0;
    logic [NR-1:0] want_g;
    int cyc = 0, cur = 0, pending;
    do_reset();
    en = '1;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 16; k++) prod_q[i].push_back(tag(i, k));
    for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) begin
      exp_grant.push_back(i);
      for (int k = 0; k < BL; k++) exp_q.push_back(tag(i, r * BL + k));
    end
    pending = 1;
    while ((pending > 0 || prev_busy) && cyc < 200) begin
      drive_sample();
      if (s_wen) begin
        total++;
        if (exp_q.size() == 0 || s_din !== exp_q[0]) begin
          bad++;
          $display("FAIL fair_data: din=%h want %h", s_din, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        cur++;
      end
      total++;
      if ((s_ready & ~s_grant) !== '0) begin
        bad++;
        $display("FAIL fair_ready_owner: ready=%b grant=%b want ready within grant", s_ready, s_grant);
      end
      if (s_busy && !prev_busy) begin
        want_g = (exp_grant.size() > 0) ? (NR'(1) << exp_grant.pop_front()) : '0;
        total++;
        if (s_grant !== want_g) begin
          bad++;
          $display("FAIL fair_order: grant=%b want %b", s_grant, want_g);
        end
      end
      if (!s_busy && prev_busy) begin
        total++;
        if (cur !== BL) begin
          bad++;
          $display("FAIL fair_burst_len: beats=%0d want %0d", cur, BL);
        end
        cur = 0;
      end
      prev_busy = s_busy;
      advance();
      cyc++;
      pending = 0;
      for (int i = 0; i < NR; i++) pending += prod_q[i].size();
    end
    total++;
    if (cyc >= 200 || exp_grant.size() !== 0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL fair_done: cycles=%0d grants_left=%0d data_left=%0d want <200 0 0",
               cyc, exp_grant.size(), exp_q.size());
    end
    en = '0;
  endtask

  task automatic test_backpressure();
    logic prev_busy = 1'b0;
    int cyc = 0, w = 0, stall_left = 5, grants = 0;
    do_reset();
    en = 4'b0001;
    for (int k = 0; k < BL; k++) begin
      prod_q[0].push_back(tag(0, k));
      exp_q.push_back(tag(0, k));
    end
    while ((prod_q[0].size() > 0 || prev_busy) && cyc < 60) begin
      full_force = (w == 3 && stall_left > 0);
      drive_sample();
      if (full_force) begin
        stall_left--;
        total++;
        if (s_wen !== 1'b0 || s_ready !== '0 || s_grant !== 4'b0001) begin
          bad++;
          $display("FAIL bp_stall: wen=%b ready=%b grant=%b want 0 0000 0001", s_wen, s_ready, s_grant);
        end
      end
      if (s_wen) begin
        total++;
        if (exp_q.size() == 0 || s_din !== exp_q[0]) begin
          bad++;
          $display("FAIL bp_data: din=%h want %h", s_din, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        w++;
      end
      if (s_busy && !prev_busy) grants++;
      prev_busy = s_busy;
      advance();
      cyc++;
    end
    full_force = 1'b0;
    total++;
    if (cyc >= 60 || grants !== 1 || w !== BL || stall_left !== 0) begin
      bad++;
      $display("FAIL bp_done: cycles=%0d grants=%0d beats=%0d stalls_left=%0d want <60 1 %0d 0",
               cyc, grants, w, stall_left, BL);
    end
    en = '0;
  endtask

  task automatic test_early_release();
    logic prev_busy = 1'b0, drop_done = 1'b0;
    logic [NR-1:0] want_g;
    int cyc = 0, cur = 0, w2 = 0, want;
    do_reset();
    en = 4'b1100;
    for (int k = 0; k < 5; k++) prod_q[2].push_back(tag(2, k));
    for (int k = 0; k < 4; k++) prod_q[3].push_back(tag(3, k));
    for (int k = 0; k < 3; k++) exp_q.push_back(tag(2, k));
    for (int k = 0; k < 4; k++) exp_q.push_back(tag(3, k));
    for (int k = 3; k < 5; k++) exp_q.push_back(tag(2, k));
    exp_grant = '{2, 3, 2};
    exp_burst = '{3, 4, 2};
    while ((prod_q[2].size() > 0 || prod_q[3].size() > 0 || prev_busy) && cyc < 80) begin
      en[2] = !(w2 == 3 && !drop_done);
      drive_sample();
      if (!en[2]) begin
        drop_done = 1'b1;
        total++;
        if (s_wen !== 1'b0 || s_busy !== 1'b1) begin
          bad++;
          $display("FAIL er_drop_cycle: wen=%b busy=%b want 0 1", s_wen, s_busy);
        end
      end
      if (s_wen) begin
        total++;
        if (exp_q.size() == 0 || s_din !== exp_q[0]) begin
          bad++;
          $display("FAIL er_data: din=%h want %h", s_din, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (s_grant[2]) w2++;
        cur++;
      end
      if (s_busy && !prev_busy) begin
        want_g = (exp_grant.size() > 0) ? (NR'(1) << exp_grant.pop_front()) : '0;
        total++;
        if (s_grant !== want_g) begin
          bad++;
          $display("FAIL er_order: grant=%b want %b", s_grant, want_g);
        end
      end
      if (!s_busy && prev_busy) begin
        want = (exp_burst.size() > 0) ? exp_burst.pop_front() : -1;
        total++;
        if (cur !== want) begin
          bad++;
          $display("FAIL er_burst_len: beats=%0d want %0d", cur, want);
        end
        cur = 0;
      end
      prev_busy = s_busy;
      advance();
      cyc++;
    end
    total++;
    if (cyc >= 80 || !drop_done || exp_q.size() !== 0 || exp_grant.size() !== 0) begin
      bad++;
      $display("FAIL er_done: cycles=%0d dropped=%b data_left=%0d grants_left=%0d want <80 1 0 0",
               cyc, drop_done, exp_q.size(), exp_grant.size());
    end
    en = '0;
  endtask

  task automatic test_stats();
    int cyc = 0, extra = 0;
    do_reset();
    fifo_cnt   = 0;
    fifo_depth = 512;
    en         = '1;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 160; k++) prod_q[i].push_back(tag(i, k));
    while (extra < 20 && cyc < 1500) begin
      drive_sample();
      if (s_full) begin
        total++;
        if (s_wen !== 1'b0) begin
          bad++;
          $display("FAIL stats_wen_while_full: wen=%b want 0", s_wen);
        end
      end
      if (fifo_cnt >= 512) extra++;
      advance();
      cyc++;
    end
    drive_sample();
    total++;
    if (cyc >= 1500 || fifo_cnt !== 512 || s_full !== 1'b1) begin
      bad++;
      $display("FAIL stats_fill: cycles=%0d fifo_cnt=%0d full=%b want <1500 512 1", cyc, fifo_cnt, s_full);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    total++;
    if (xfer_total !== 32'd512) begin
      bad++;
      $display("FAIL stats_xfer_total: xfer_total=%0d want 512", xfer_total);
    end
`endif
    en = '0;
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    fifo_depth = 1 << 30;
  endtask

  initial begin
    rst           = 1'b1;
    en            = '0;
    full_force    = 1'b0;
    fifo_cnt      = 0;
    fifo_depth    = 1 << 30;
    total         = 0;
    bad           = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
